// File: rtl/ins_miss_queue_pkg.sv
// Shared defaults and helpers for the instruction miss queue.
// Coalescing of duplicate line requests is enabled by defining MISSQ_COALESCE_EN.
package ins_miss_queue_pkg;

  localparam int DEF_DEPTH       = 8;
  localparam int DEF_ADDR_W      = 26;
  localparam int DEF_OFFSET_BITS = 6;
  localparam int CNT_W           = 32;

  // The caller casts the result down to its own address width.
  function automatic logic [63:0] line_mask(input int offset_bits);
    return {64{1'b1}} << offset_bits;
  endfunction

endpackage

// File: rtl/missq_match.sv
// DEPTH-way comparator: reports whether the probe line equals any valid entry.
module missq_match #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 26
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] entries,
  input  logic [DEPTH-1:0]             valid,
  input  logic [ADDR_W-1:0]            probe,
  output logic                         any_match
);

  always_comb begin
    any_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i] == probe)) any_match = 1'b1;
    end
  end

endmodule

// File: rtl/ins_miss_queue.sv
// In-order miss/fill line queue toward L2 with optional coalescing (MISSQ_COALESCE_EN)
// and issued/dropped/merged statistics counters.
module ins_miss_queue
  import ins_miss_queue_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       miss_valid,
  input  logic [ADDR_W-1:0]          miss_addr,
  output logic                       req_valid,
  output logic [ADDR_W-1:0]          req_addr,
  input  logic                       req_ready,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       full,
  output logic                       empty,
  output logic [CNT_W-1:0]           merged_cnt,
  output logic [CNT_W-1:0]           dropped_cnt,
  output logic [CNT_W-1:0]           issued_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(line_mask(OFFSET_BITS));

  logic [DEPTH-1:0][ADDR_W-1:0] mem;
  logic [PTR_W-1:0]             head;
  logic [PTR_W-1:0]             tail;
  logic [PTR_W:0]               occ;
  logic [CNT_W-1:0]             issued_q;
  logic [CNT_W-1:0]             dropped_q;
  logic [ADDR_W-1:0]            line_addr;
  logic                         merge;
  logic                         push;
  logic                         pop;
  logic                         drop;

  assign line_addr = miss_addr & LINE_MASK;
  assign empty     = (occ == '0);
  assign full      = (occ == (PTR_W+1)'(DEPTH));
  assign req_valid = !empty;
  // Masked so a stale slot never shows on req_addr after reset or flush.
  assign req_addr  = req_valid ? mem[head] : '0;
  assign occupancy = occ;
  assign pop       = req_valid && req_ready;
  assign push      = miss_valid && !merge && (!full || pop);
  assign drop      = miss_valid && !merge && full && !pop;

  assign issued_cnt  = issued_q;
  assign dropped_cnt = dropped_q;

`ifdef MISSQ_COALESCE_EN
  logic [DEPTH-1:0] vld;
  logic             any_match;
  logic [CNT_W-1:0] merged_q;

  missq_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_match (
    .entries   (mem),
    .valid     (vld),
    .probe     (line_addr),
    .any_match (any_match)
  );

  assign merge      = miss_valid && any_match;
  assign merged_cnt = merged_q;

  // On a full push+pop, head == tail; the push set must win over the pop clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld      <= '0;
      merged_q <= '0;
    end else if (flush) begin
      vld      <= '0;
      merged_q <= '0;
    end else begin
      if (pop)   vld[head] <= 1'b0;
      if (push)  vld[tail] <= 1'b1;
      if (merge) merged_q  <= merged_q + 1'b1;
    end
  end
`else
  assign merge      = 1'b0;
  assign merged_cnt = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      issued_q  <= '0;
      dropped_q <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      issued_q  <= '0;
      dropped_q <= '0;
    end else begin
      if (push) begin
        mem[tail] <= line_addr;
        tail      <= tail + 1'b1;
      end
      if (pop) begin
        head     <= head + 1'b1;
        issued_q <= issued_q + 1'b1;
      end
      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;
      if (drop) dropped_q <= dropped_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_ins_miss_queue.sv
// Scoreboard bench for ins_miss_queue; expectations follow MISSQ_COALESCE_EN if defined.
module tb_ins_miss_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        miss_valid = 1'b0;
  logic [25:0] miss_addr = '0;
  logic        req_valid;
  logic [25:0] req_addr;
  logic        req_ready = 1'b0;
  logic [3:0]  occupancy;
  logic        full;
  logic        empty;
  logic [31:0] merged_cnt;
  logic [31:0] dropped_cnt;
  logic [31:0] issued_cnt;

  int tests = 0;
  int fails = 0;

  logic [25:0] exp_q[$];
  int unsigned m_merged = 0;
  int unsigned m_dropped = 0;
  int unsigned m_issued = 0;

  localparam logic [25:0] MASK = 26'h3FFFFC0;

  always #5 clk = ~clk;

  ins_miss_queue dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .miss_valid  (miss_valid),
    .miss_addr   (miss_addr),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .occupancy   (occupancy),
    .full        (full),
    .empty       (empty),
    .merged_cnt  (merged_cnt),
    .dropped_cnt (dropped_cnt),
    .issued_cnt  (issued_cnt)
  );

  task automatic model_clear();
    exp_q.delete();
    m_merged = 0;
    m_dropped = 0;
    m_issued = 0;
  endtask

  task automatic check_state(input string tag);
    tests++;
    if (occupancy !== 4'(exp_q.size())) begin
      fails++; $display("FAIL %s occupancy got %0d want %0d", tag, occupancy, exp_q.size());
    end
    tests++;
    if (empty !== (exp_q.size() == 0)) begin
      fails++; $display("FAIL %s empty got %b want %b", tag, empty, exp_q.size() == 0);
    end
    tests++;
    if (full !== (exp_q.size() == 8)) begin
      fails++; $display("FAIL %s full got %b want %b", tag, full, exp_q.size() == 8);
    end
    tests++;
    if (issued_cnt !== m_issued) begin
      fails++; $display("FAIL %s issued_cnt got %0d want %0d", tag, issued_cnt, m_issued);
    end
    tests++;
    if (dropped_cnt !== m_dropped) begin
      fails++; $display("FAIL %s dropped_cnt got %0d want %0d", tag, dropped_cnt, m_dropped);
    end
    tests++;
    if (merged_cnt !== m_merged) begin
      fails++; $display("FAIL %s merged_cnt got %0d want %0d", tag, merged_cnt, m_merged);
    end
  endtask

  // Called just after a falling edge: drives one cycle, scoreboards the handshake, checks state.
  task automatic step(input logic mv, input logic [25:0] ma, input logic rdy);
    logic        hs;
    logic        match;
    logic        was_full;
    logic [25:0] line;
    miss_valid = mv;
    miss_addr  = ma;
    req_ready  = rdy;
    #1;
    tests++;
    if (req_valid !== (exp_q.size() != 0)) begin
      fails++; $display("FAIL step req_valid got %b want %b", req_valid, exp_q.size() != 0);
    end
    hs = (exp_q.size() != 0) && rdy;
    if (exp_q.size() != 0) begin
      tests++;
      if (req_addr !== exp_q[0]) begin
        fails++; $display("FAIL step req_addr got %h want %h", req_addr, exp_q[0]);
      end
    end
    line = ma & MASK;
    match = 1'b0;
`ifdef MISSQ_COALESCE_EN
    foreach (exp_q[i]) if (exp_q[i] == line) match = 1'b1;
`endif
    was_full = (exp_q.size() == 8);
    if (hs) begin
      void'(exp_q.pop_front());
      m_issued++;
    end
    if (mv) begin
      if (match) m_merged++;
      else if (!was_full || hs) exp_q.push_back(line);
      else m_dropped++;
    end
    @(posedge clk);
    @(negedge clk);
    miss_valid = 1'b0;
    req_ready  = 1'b0;
    check_state("step");
  endtask

  task automatic drain();
    for (int i = 0; i < 16; i++) begin
      if (exp_q.size() == 0) break;
      step(1'b0, '0, 1'b1);
    end
    tests++;
    if (empty !== 1'b1) begin
      fails++; $display("FAIL drain empty got %b want 1 (budget expired)", empty);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
    tests++;
    if (req_valid !== 1'b0 || req_addr !== 26'h0) begin
      fails++; $display("FAIL reset req got v=%b a=%h want v=0 a=0", req_valid, req_addr);
    end
    check_state("reset");
  endtask

  task automatic test_single();
    step(1'b1, 26'h0012345, 1'b0);
    tests++;
    if (req_valid !== 1'b1 || req_addr !== 26'h0012340 || occupancy !== 4'd1 || empty !== 1'b0) begin
      fails++; $display("FAIL single req v=%b a=%h occ=%0d empty=%b want 1 0012340 1 0",
                        req_valid, req_addr, occupancy, empty);
    end
    step(1'b0, '0, 1'b1);
    tests++;
    if (empty !== 1'b1 || issued_cnt !== 32'd1) begin
      fails++; $display("FAIL single_pop empty=%b issued=%0d want 1 1", empty, issued_cnt);
    end
  endtask

  task automatic test_coalesce();
    step(1'b1, 26'h0000040, 1'b0);
    step(1'b1, 26'h000007F, 1'b0);
    step(1'b1, 26'h0000080, 1'b0);
    tests++;
`ifdef MISSQ_COALESCE_EN
    if (occupancy !== 4'd2 || merged_cnt !== 32'd1) begin
      fails++; $display("FAIL coalesce occ=%0d merged=%0d want 2 1", occupancy, merged_cnt);
    end
`else
    if (occupancy !== 4'd3 || merged_cnt !== 32'd0) begin
      fails++; $display("FAIL coalesce occ=%0d merged=%0d want 3 0", occupancy, merged_cnt);
    end
`endif
    tests++;
    if (req_addr !== 26'h0000040) begin
      fails++; $display("FAIL coalesce_head got %h want 0000040", req_addr);
    end
    drain();
  endtask

  task automatic test_full();
    int unsigned d0;
    int unsigned i0;
    for (int i = 0; i < 8; i++) step(1'b1, 26'h1000 + 26'(i * 26'h100), 1'b0);
    tests++;
    if (full !== 1'b1) begin
      fails++; $display("FAIL full_flag got %b want 1", full);
    end
    d0 = dropped_cnt;
    step(1'b1, 26'h0000900, 1'b0);
    tests++;
    if (dropped_cnt !== d0 + 1 || occupancy !== 4'd8 || req_addr !== 26'h0001000) begin
      fails++; $display("FAIL full_drop dropped=%0d occ=%0d head=%h want %0d 8 0001000",
                        dropped_cnt, occupancy, req_addr, d0 + 1);
    end
    i0 = issued_cnt;
    step(1'b1, 26'h0000900, 1'b1);
    tests++;
    if (occupancy !== 4'd8 || issued_cnt !== i0 + 1 || dropped_cnt !== d0 + 1) begin
      fails++; $display("FAIL full_accept occ=%0d issued=%0d dropped=%0d want 8 %0d %0d",
                        occupancy, issued_cnt, dropped_cnt, i0 + 1, d0 + 1);
    end
    drain();
  endtask

  task automatic test_wrap();
    int unsigned i0;
    int pushed;
    i0 = issued_cnt;
    pushed = 0;
    for (int c = 0; c < 40; c++) begin
      if ((c % 2 == 0) && pushed < 20) begin
        step(1'b1, 26'h20000 + 26'(pushed * 26'h40) + 26'h5, 1'b0);
        pushed++;
      end else begin
        step(1'b0, '0, 1'b1);
      end
    end
    drain();
    tests++;
    if (issued_cnt !== i0 + 20 || empty !== 1'b1) begin
      fails++; $display("FAIL wrap issued=%0d empty=%b want %0d 1", issued_cnt, empty, i0 + 20);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) step(1'b1, 26'h30000 + 26'(i * 26'h40), 1'b0);
    flush = 1'b1;
    miss_valid = 1'b1;
    miss_addr = 26'h0031000;
    req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    miss_valid = 1'b0;
    req_ready = 1'b0;
    model_clear();
    tests++;
    if (occupancy !== 4'd0 || req_valid !== 1'b0 || issued_cnt !== 32'd0 ||
        dropped_cnt !== 32'd0 || merged_cnt !== 32'd0) begin
      fails++; $display("FAIL flush occ=%0d v=%b iss=%0d drp=%0d mrg=%0d want all 0",
                        occupancy, req_valid, issued_cnt, dropped_cnt, merged_cnt);
    end
    check_state("flush");
    step(1'b1, 26'h0000200, 1'b0);
    step(1'b1, 26'h0000240, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (req_valid !== 1'b0 || occupancy !== 4'd0 || issued_cnt !== 32'd0) begin
      fails++; $display("FAIL async_reset v=%b occ=%0d iss=%0d want 0 0 0",
                        req_valid, occupancy, issued_cnt);
    end
    #1;
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    check_state("after_reset");
  endtask

  task automatic test_merge_head();
    int unsigned m0;
    step(1'b1, 26'h0000140, 1'b0);
    step(1'b1, 26'h0000200, 1'b0);
    m0 = merged_cnt;
    step(1'b1, 26'h0000155, 1'b1);
    tests++;
`ifdef MISSQ_COALESCE_EN
    if (merged_cnt !== m0 + 1 || occupancy !== 4'd1) begin
      fails++; $display("FAIL merge_head merged=%0d occ=%0d want %0d 1", merged_cnt, occupancy, m0 + 1);
    end
`else
    if (merged_cnt !== 32'd0 || occupancy !== 4'd2) begin
      fails++; $display("FAIL merge_head merged=%0d occ=%0d want 0 2", merged_cnt, occupancy);
    end
`endif
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_coalesce();
    test_full();
    test_wrap();
    test_flush();
    test_merge_head();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
